// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, HI/LO read
// qualifiers and the controller state encoding.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] MOVE_NONE = 2'b00;
  localparam logic [1:0] MOVE_HI   = 2'b01;
  localparam logic [1:0] MOVE_LO   = 2'b10;
  localparam logic [1:0] MOVE_BOTH = 2'b11;

  // Wide enough to hold MULT_LAT-1 for the largest legal latency (8).
  localparam int MUL_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } state_t;

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first.
// Loads magnitudes on start, then runs WIDTH iterations. done is high during
// the cycle whose closing edge performs the final iteration, so quotient and
// remainder are final in the cycle after done.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  // Partial remainder shifted left with the next dividend bit brought in.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] sub;
  logic             ge;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign ge      = shifted >= {1'b0, dvs_q};
  // When ge holds the difference is below the divisor, so it fits in WIDTH bits.
  assign sub     = shifted[WIDTH-1:0] - dvs_q;

  // Next-state for the shift registers and the iteration counter.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = CNT_W'(WIDTH - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = ge ? sub : shifted[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ge};
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Divider state registers; reset discards any division in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done      = run_q && (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Raises a combinational stall request while busy whenever the execute stage
// wants the unit or HI/LO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MULT_LAT = 3,
  parameter int WIDTH    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             starte,
  input  logic [1:0]       ope,
  input  logic [WIDTH-1:0] srcae,
  input  logic [WIDTH-1:0] srcbe,
  input  logic [1:0]       movee,
  input  logic             mthie,
  input  logic             mtloe,
  input  logic [WIDTH-1:0] wdatae,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stallreq
);

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [1:0]             op_q, op_d;
  logic [MUL_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   q_neg_q, q_neg_d;
  logic                   r_neg_q, r_neg_d;
  logic                   dz_q, dz_d;
  logic                   busy_q, busy_d;

  logic                   div_start;
  logic                   div_done;
  logic [WIDTH-1:0]       div_quo;
  logic [WIDTH-1:0]       div_rem;
  logic                   div_signed;
  logic [WIDTH-1:0]       mag_a;
  logic [WIDTH-1:0]       mag_b;

  logic                   mul_signed;
  logic [2*WIDTH-1:0]     ext_a;
  logic [2*WIDTH-1:0]     ext_b;
  logic [2*WIDTH-1:0]     product;

  // Divider magnitudes come straight from the operand bus on the accept cycle.
  assign div_signed = (ope == OP_DIV);
  assign mag_a      = (div_signed && srcae[WIDTH-1]) ? -srcae : srcae;
  assign mag_b      = (div_signed && srcbe[WIDTH-1]) ? -srcbe : srcbe;

  // Sign- or zero-extend to full width so the low 2W bits of the product are
  // correct for both mult and multu.
  assign mul_signed = (op_q == OP_MULT);
  assign ext_a      = {{WIDTH{mul_signed & a_q[WIDTH-1]}}, a_q};
  assign ext_b      = {{WIDTH{mul_signed & b_q[WIDTH-1]}}, b_q};
  assign product    = ext_a * ext_b;

  div_iter #(
    .WIDTH(WIDTH)
  ) u_div_iter (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (mag_a),
    .divisor  (mag_b),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  // Controller next-state: acceptance, multiply countdown, division
  // sequencing, sign fix-up and the mthi/mtlo writes.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    dz_d      = dz_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (starte) begin
          a_d  = srcae;
          b_d  = srcbe;
          op_d = ope;
          if (ope[1] == 1'b0) begin
            state_d = ST_MUL;
            cnt_d   = MUL_CNT_W'(MULT_LAT - 1);
          end else begin
            state_d   = ST_DIV;
            div_start = 1'b1;
            q_neg_d   = div_signed & (srcae[WIDTH-1] ^ srcbe[WIDTH-1]);
            r_neg_d   = div_signed & srcae[WIDTH-1];
            dz_d      = (srcbe == '0);
          end
        end else begin
          if (mthie) hi_d = wdatae;
          if (mtloe) lo_d = wdatae;
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          hi_d    = product[2*WIDTH-1:WIDTH];
          lo_d    = product[WIDTH-1:0];
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - MUL_CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (div_done) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (dz_q) begin
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = q_neg_q ? -div_quo : div_quo;
          hi_d = r_neg_q ? -div_rem : div_rem;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Controller and HI/LO registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_MULT;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign stallreq = busy_q & (starte | (movee != MOVE_NONE) | mthie | mtloe);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int MULT_LAT = 3;
  localparam int DIV_LAT  = 33;
  localparam int TIMEOUT  = 100;

  logic        clk;
  logic        reset;
  logic        starte;
  logic [1:0]  ope;
  logic [31:0] srcae;
  logic [31:0] srcbe;
  logic [1:0]  movee;
  logic        mthie;
  logic        mtloe;
  logic [31:0] wdatae;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stallreq;

  int testsRun  = 0;
  int failCount = 0;

  muldiv_unit #(
    .MULT_LAT(MULT_LAT),
    .WIDTH   (32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .starte  (starte),
    .ope     (ope),
    .srcae   (srcae),
    .srcbe   (srcbe),
    .movee   (movee),
    .mthie   (mthie),
    .mtloe   (mtloe),
    .wdatae  (wdatae),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .stallreq(stallreq)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} computed with plain 64-bit arithmetic.
  function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    res = '0;
    case (op)
      OP_MULT:  res = 64'(sa * sb);
      OP_MULTU: res = ua * ub;
      default: begin
        if (b == 32'h0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          if (op == OP_DIV) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'(ua / ub);
            r = longint'(ua % ub);
          end
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Issue one mult/div, watch every busy cycle, then check the result.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] mv, input bit pulse, input bit withMove);
    logic [63:0] expRes;
    logic [31:0] oldHi;
    logic [31:0] oldLo;
    int          n;
    int          expLat;
    bit          held;
    logic        expStall;
    expRes = refModel(op, a, b);
    expLat = op[1] ? DIV_LAT : MULT_LAT;
    @(negedge clk);
    oldHi  = hi;
    oldLo  = lo;
    starte = 1'b1;
    ope    = op;
    srcae  = a;
    srcbe  = b;
    if (withMove) begin
      mthie  = 1'b1;
      mtloe  = 1'b1;
      wdatae = 32'hDEAD_BEEF;
    end
    @(posedge clk);
    #1;
    starte = 1'b0;
    mthie  = 1'b0;
    mtloe  = 1'b0;
    srcae  = $urandom;
    srcbe  = $urandom;
    movee  = mv;
    n      = 0;
    held   = 1'b1;
    while (n < TIMEOUT) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      expStall = (mv != MOVE_NONE) | starte;
      checkOutput("stallreq_busy", {31'b0, stallreq}, {31'b0, expStall});
      if (hi !== oldHi || lo !== oldLo) held = 1'b0;
      if (pulse && n == 5) begin
        starte = 1'b1;
        ope    = OP_MULT;
        srcae  = $urandom;
        srcbe  = $urandom;
      end else begin
        starte = 1'b0;
      end
    end
    starte = 1'b0;
    checkOutput("busy_cycles", n, expLat);
    checkOutput("stallreq_idle", {31'b0, stallreq}, 32'h0);
    checkOutput("hilo_held", {31'b0, held}, 32'h1);
    checkOutput("hi", hi, expRes[63:32]);
    checkOutput("lo", lo, expRes[31:0]);
    movee = MOVE_NONE;
  endtask

  // Main sequence: reset, directed cases, random cases, mid-operation reset.
  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    reset  = 1'b1;
    starte = 1'b0;
    ope    = OP_MULT;
    srcae  = '0;
    srcbe  = '0;
    movee  = MOVE_NONE;
    mthie  = 1'b0;
    mtloe  = 1'b0;
    wdatae = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_hi", hi, 32'h0);
    checkOutput("reset_lo", lo, 32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_stallreq", {31'b0, stallreq}, 32'h0);
    reset = 1'b0;

    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MOVE_NONE, 1'b0, 1'b0);
    applyStimulus(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, MOVE_BOTH, 1'b0, 1'b0);
    applyStimulus(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, MOVE_HI,   1'b1, 1'b0);
    applyStimulus(OP_DIVU,  32'd100,       32'd7,         MOVE_NONE, 1'b0, 1'b1);
    applyStimulus(OP_DIVU,  32'h0000_1234, 32'h0,         MOVE_LO,   1'b0, 1'b0);
    applyStimulus(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, MOVE_NONE, 1'b0, 1'b0);
    applyStimulus(OP_DIV,   32'h8765_4321, 32'h0,         MOVE_NONE, 1'b0, 1'b0);
    applyStimulus(OP_MULT,  32'h1234_5678, 32'h9ABC_DEF0, MOVE_NONE, 1'b0, 1'b1);

    // mthi and mtlo together in IDLE write both registers.
    @(negedge clk);
    mthie  = 1'b1;
    mtloe  = 1'b1;
    wdatae = 32'h55AA_33CC;
    @(posedge clk);
    #1;
    mthie = 1'b0;
    mtloe = 1'b0;
    checkOutput("mthi_both", hi, 32'h55AA_33CC);
    checkOutput("mtlo_both", lo, 32'h55AA_33CC);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       ra = 32'h0;
        1:       ra = 32'hFFFF_FFFF;
        2:       ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'h0000_0001;
        3:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      applyStimulus(rop, ra, rb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Make HI/LO nonzero, then reset in the middle of a divide.
    @(negedge clk);
    mthie  = 1'b1;
    mtloe  = 1'b1;
    wdatae = 32'h0F0F_F0F0;
    @(posedge clk);
    #1;
    mthie  = 1'b0;
    mtloe  = 1'b0;
    @(negedge clk);
    starte = 1'b1;
    ope    = OP_DIV;
    srcae  = 32'hFFFF_FFF9;
    srcbe  = 32'h0000_0002;
    @(posedge clk);
    #1;
    starte = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("busy_before_reset", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("midreset_hi", hi, 32'h0);
    checkOutput("midreset_lo", lo, 32'h0);
    checkOutput("midreset_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mtloe  = 1'b1;
    wdatae = 32'h0000_ABCD;
    @(posedge clk);
    #1;
    mtloe = 1'b0;
    checkOutput("mtlo_after_reset", lo, 32'h0000_ABCD);
    checkOutput("hi_after_reset", hi, 32'h0);
    repeat (40) @(negedge clk);
    checkOutput("no_stale_result_lo", lo, 32'h0000_ABCD);
    checkOutput("no_stale_busy", {31'b0, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
